// File: rtl/clk_switch_sequencer_pkg.sv
// Shared clock-mode encodings and the DVFS switch sequencer state type.
// Pure declarations plus one mode-legalisation helper; no logic or latency of its own.
package clk_switch_sequencer_pkg;

  typedef logic [1:0] clk_mode_t;

  localparam clk_mode_t CLK_MODE_FAST    = 2'b00;
  localparam clk_mode_t CLK_MODE_SLOW    = 2'b01;
  localparam clk_mode_t CLK_MODE_NOMINAL = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    SWITCH  = 3'd2,
    SETTLE  = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  // The unused encoding 2'b11 is treated as a request for nominal.
  function automatic clk_mode_t legal_mode(input logic [1:0] req);
    return (req == 2'b11) ? CLK_MODE_NOMINAL : clk_mode_t'(req);
  endfunction

endpackage

// File: rtl/clk_reset_sync.sv
// Async-assert / sync-deassert reset for tile logic in the clk_out domain.
// rst_out falls on the 2nd clk_out posedge after clk_reset falls; no handshake.
module clk_reset_sync (
  input  logic clk_out,
  input  logic clk_reset,
  output logic rst_out
);

  logic [1:0] r_sync;

  always_ff @(posedge clk_out or posedge clk_reset) begin
    if (clk_reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], 1'b0};
    end
  end

  assign rst_out = r_sync[1];

endmodule

// File: rtl/clk_switch_sequencer.sv
// Sequences a glitch-safe DVFS clock change: stall tile, drive switcher, settle, acknowledge.
// Mode change takes 12 cycles at defaults (same-mode: 1); one request at a time, req_rdy low while busy.
module clk_switch_sequencer
  import clk_switch_sequencer_pkg::*;
#(
  parameter int unsigned QUIESCE_CYCLES = 2,
  parameter int unsigned SWITCH_HOLD    = 5,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk_out,
  input  logic       clk_reset,
  output logic       rst_out,
  input  logic       req_val,
  output logic       req_rdy,
  input  logic [1:0] req_msg,
  output logic       resp_val,
  output logic       stall,
  input  logic       idle,
  output logic       switch_val,
  input  logic       switch_rdy,
  output logic [1:0] switch_msg,
  output logic [1:0] cur_mode,
  output logic       busy
);

  if ((QUIESCE_CYCLES < 1) || (QUIESCE_CYCLES >= (1 << CNT_W)) ||
      (SWITCH_HOLD    < 1) || (SWITCH_HOLD    >= (1 << CNT_W)) ||
      (SETTLE_CYCLES  < 1) || (SETTLE_CYCLES  >= (1 << CNT_W))) begin : g_param_check
    $error("clk_switch_sequencer: cycle parameters must be in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SWITCH_LAST  = CNT_W'(SWITCH_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  clk_mode_t        r_target;
  clk_mode_t        r_cur_mode;
  clk_mode_t        r_switch_msg;
  clk_mode_t        w_req_mode;
  logic             w_accept;
  logic             w_sw_fire;
  logic             w_cnt_inc;

  clk_reset_sync u_rst_sync (
    .clk_out   (clk_out),
    .clk_reset (clk_reset),
    .rst_out   (rst_out)
  );

  assign w_req_mode = legal_mode(req_msg);
  assign w_accept   = req_val & req_rdy;
  assign w_sw_fire  = switch_val & switch_rdy;
  assign w_cnt_inc  = (r_state == QUIESCE) || (r_state == SETTLE) ||
                      ((r_state == SWITCH) && w_sw_fire);

  always_ff @(posedge clk_out or posedge clk_reset) begin
    if (clk_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (w_req_mode == r_cur_mode) ? DONE : QUIESCE;
      QUIESCE: if ((r_cnt >= QUIESCE_LAST) && idle) w_state_nxt = SWITCH;
      SWITCH:  if (w_sw_fire && (r_cnt == SWITCH_LAST)) w_state_nxt = SETTLE;
      SETTLE:  if (r_cnt == SETTLE_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_rdy    = (r_state == IDLE) & ~rst_out;
    resp_val   = 1'b0;
    stall      = 1'b0;
    switch_val = 1'b0;
    busy       = (r_state != IDLE);
    switch_msg = r_switch_msg;
    cur_mode   = r_cur_mode;
    unique case (r_state)
      QUIESCE: stall = 1'b1;
      SWITCH: begin
        stall      = 1'b1;
        switch_val = 1'b1;
      end
      SETTLE:  stall = 1'b1;
      DONE:    resp_val = 1'b1;
      default: ;
    endcase
  end

  // Counter restarts on every state change and saturates rather than wrapping.
  always_ff @(posedge clk_out or posedge clk_reset) begin
    if (clk_reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // cur_mode flips as DONE is entered so it is valid alongside resp_val.
  always_ff @(posedge clk_out or posedge clk_reset) begin
    if (clk_reset) begin
      r_target     <= CLK_MODE_NOMINAL;
      r_cur_mode   <= CLK_MODE_NOMINAL;
      r_switch_msg <= CLK_MODE_NOMINAL;
    end else begin
      if (w_accept) begin
        r_target <= w_req_mode;
      end
      if ((w_state_nxt == SWITCH) && (r_state != SWITCH)) begin
        r_switch_msg <= r_target;
      end
      if ((w_state_nxt == DONE) && (r_state != DONE)) begin
        r_cur_mode <= (r_state == IDLE) ? w_req_mode : r_target;
      end
    end
  end

endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Directed bench for clk_switch_sequencer: reset, mode changes, idle stall, illegal/same mode, mid-switch reset.
module tb_clk_switch_sequencer;

  logic       clk_out;
  logic       clk_reset;
  logic       clk_en;
  logic       rst_out;
  logic       req_val;
  logic       req_rdy;
  logic [1:0] req_msg;
  logic       resp_val;
  logic       stall;
  logic       idle;
  logic       switch_val;
  logic       switch_rdy;
  logic [1:0] switch_msg;
  logic [1:0] cur_mode;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  clk_switch_sequencer dut (
    .clk_out    (clk_out),
    .clk_reset  (clk_reset),
    .rst_out    (rst_out),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_msg    (req_msg),
    .resp_val   (resp_val),
    .stall      (stall),
    .idle       (idle),
    .switch_val (switch_val),
    .switch_rdy (switch_rdy),
    .switch_msg (switch_msg),
    .cur_mode   (cur_mode),
    .busy       (busy)
  );

  // Clock is held low whenever clk_en is off, as the switcher does during reset.
  initial begin
    clk_out = 1'b0;
    forever begin
      #5;
      if (clk_en) clk_out = ~clk_out;
      else        clk_out = 1'b0;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_out);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    clk_en     = 1'b0;
    clk_reset  = 1'b1;
    req_val    = 1'b0;
    req_msg    = 2'b00;
    idle       = 1'b1;
    switch_rdy = 1'b1;
    #20;
    chk("rst_rst_out",    rst_out,    1);
    chk("rst_req_rdy",    req_rdy,    0);
    chk("rst_resp_val",   resp_val,   0);
    chk("rst_stall",      stall,      0);
    chk("rst_switch_val", switch_val, 0);
    chk("rst_switch_msg", switch_msg, 2'b10);
    chk("rst_cur_mode",   cur_mode,   2'b10);
    chk("rst_busy",       busy,       0);

    clk_reset = 1'b0;
    clk_en    = 1'b1;
    step();
    chk("rel_rst_out_1st", rst_out, 1);
    chk("rel_req_rdy_1st", req_rdy, 0);
    step();
    chk("rel_rst_out_2nd", rst_out, 0);
    chk("rel_req_rdy_2nd", req_rdy, 1);

    // Nominal -> fast; idle wobbles in SWITCH/SETTLE and a request arrives while busy.
    req_val = 1'b1;
    req_msg = 2'b00;
    step();
    req_val = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("nf_stall_k%0d", k),      stall,      (k <= 11));
      chk($sformatf("nf_switch_val_k%0d", k), switch_val, (k >= 3 && k <= 7));
      chk($sformatf("nf_resp_val_k%0d", k),   resp_val,   (k == 12));
      chk($sformatf("nf_busy_k%0d", k),       busy,       (k <= 12));
      if (k == 3)  chk("nf_switch_msg", switch_msg, 2'b00);
      if (k == 5)  chk("nf_req_rdy_busy", req_rdy, 0);
      if (k == 12) chk("nf_cur_mode_done", cur_mode, 2'b00);
      if (k == 13) chk("nf_cur_mode_after", cur_mode, 2'b00);
      req_val = (k == 4 || k == 5);
      req_msg = 2'b01;
      idle    = !(k >= 6 && k <= 9);
      if (k < 13) step();
    end

    // Fast -> slow with idle held low, then switch_rdy withheld for three SWITCH cycles.
    req_val = 1'b1;
    req_msg = 2'b01;
    idle    = 1'b0;
    step();
    req_val = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("iq_stall_k%0d", k),      stall,      1);
      chk($sformatf("iq_switch_val_k%0d", k), switch_val, 0);
      if (k < 10) step();
    end
    idle = 1'b1;
    step();
    chk("iq_switch_start", switch_val, 1);
    chk("iq_switch_msg",   switch_msg, 2'b01);
    switch_rdy = 1'b0;
    for (int j = 2; j <= 4; j++) begin
      step();
      chk($sformatf("iq_norrdy_switch_j%0d", j), switch_val, 1);
    end
    switch_rdy = 1'b1;
    for (int j = 5; j <= 13; j++) begin
      step();
      chk($sformatf("iq_switch_val_j%0d", j), switch_val, (j <= 8));
      chk($sformatf("iq_stall_j%0d", j),      stall,      (j <= 12));
      chk($sformatf("iq_resp_val_j%0d", j),   resp_val,   (j == 13));
    end
    chk("iq_cur_mode", cur_mode, 2'b01);
    step();
    chk("iq_busy_end", busy, 0);

    // Illegal encoding 11 from slow is treated as nominal.
    req_val = 1'b1;
    req_msg = 2'b11;
    step();
    req_val = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin
        chk("il_switch_val", switch_val, 1);
        chk("il_switch_msg", switch_msg, 2'b10);
      end
      if (k == 11) chk("il_cur_mode_before", cur_mode, 2'b01);
      if (k == 12) begin
        chk("il_resp_val", resp_val, 1);
        chk("il_cur_mode", cur_mode, 2'b10);
      end
      if (k < 12) step();
    end
    step();
    chk("il_switch_msg_hold", switch_msg, 2'b10);
    chk("il_req_rdy",         req_rdy,    1);

    // Same-mode request completes in one cycle with no stall.
    req_val = 1'b1;
    req_msg = 2'b10;
    step();
    req_val = 1'b0;
    chk("sm_resp_val",   resp_val,   1);
    chk("sm_stall",      stall,      0);
    chk("sm_switch_val", switch_val, 0);
    chk("sm_busy",       busy,       1);
    step();
    chk("sm_resp_val_after", resp_val, 0);
    chk("sm_busy_after",     busy,     0);
    chk("sm_stall_after",    stall,    0);
    chk("sm_cur_mode",       cur_mode, 2'b10);

    // Reset pulse in the middle of SWITCH.
    req_val = 1'b1;
    req_msg = 2'b00;
    step();
    req_val = 1'b0;
    step();
    step();
    chk("mr_switch_val_pre", switch_val, 1);
    chk("mr_switch_msg_pre", switch_msg, 2'b00);
    clk_en    = 1'b0;
    clk_reset = 1'b1;
    #1;
    chk("mr_switch_val", switch_val, 0);
    chk("mr_stall",      stall,      0);
    chk("mr_busy",       busy,       0);
    chk("mr_cur_mode",   cur_mode,   2'b10);
    chk("mr_switch_msg", switch_msg, 2'b10);
    chk("mr_rst_out",    rst_out,    1);
    chk("mr_req_rdy",    req_rdy,    0);
    #20;
    clk_reset = 1'b0;
    clk_en    = 1'b1;
    step();
    chk("mr_rst_out_1st", rst_out, 1);
    step();
    chk("mr_rst_out_2nd", rst_out, 0);
    chk("mr_req_rdy_2nd", req_rdy, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mr_quiet_resp_%0d", k), resp_val, 0);
      chk($sformatf("mr_quiet_busy_%0d", k), busy,     0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
